// File: rtl/sdram_frame_port_arb.sv
// rtl/sdram_frame_port_arb.sv - SDRAM burst arbiter between a camera write FIFO and a display read FIFO
// Ping-pong frame buffers; one request pulse per burst, re-issued on NACK, on no-accept or after a timeout.
module sdram_frame_port_arb #(
    parameter int                          SDRAM_ADDRS_WIDE = 21,
    parameter int                          SDRAM_DATA_WIDE  = 32,
    parameter int                          FIFO_LVL_WIDE    = 10,
    parameter logic [7:0]                  BURST_LEN        = 8'd64,
    parameter logic [SDRAM_ADDRS_WIDE-1:0] FRAME_WORDS      = 21'd76800,
    parameter logic [SDRAM_ADDRS_WIDE-1:0] BUF0_BASE        = 21'd0,
    parameter logic [SDRAM_ADDRS_WIDE-1:0] BUF1_BASE        = 21'd131072,
    parameter logic [15:0]                 TIMEOUT_CYC      = 16'd4095
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_sdram_init_done,
    input  logic                        i_wr_frame_start,
    input  logic                        i_rd_frame_start,
    input  logic [FIFO_LVL_WIDE-1:0]    i_wr_fifo_lvl,
    input  logic [FIFO_LVL_WIDE-1:0]    i_rd_fifo_free,
    output logic                        o_wr_fifo_rd_en,
    output logic                        o_wr_en,
    output logic [7:0]                  o_wr_lengths,
    output logic [SDRAM_ADDRS_WIDE-1:0] o_wr_addrs,
    output logic [3:0]                  o_wr_dqm,
    output logic                        o_rd_en,
    output logic [7:0]                  o_rd_lengths,
    output logic [SDRAM_ADDRS_WIDE-1:0] o_rd_addrs,
    output logic [3:0]                  o_rd_dqm,
    input  logic                        i_wr_data_req,
    input  logic                        i_rw_over,
    input  logic                        i_rd_wr_done,
    input  logic                        i_rw_nack,
    output logic                        o_err_timeout,
    output logic                        o_wr_buf
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    localparam logic [SDRAM_ADDRS_WIDE-1:0] BURST_STEP  = SDRAM_ADDRS_WIDE'(BURST_LEN) + SDRAM_ADDRS_WIDE'(1);
    localparam logic [FIFO_LVL_WIDE-1:0]    BURST_WORDS = FIFO_LVL_WIDE'(BURST_LEN) + FIFO_LVL_WIDE'(1);

    state_t                      state_q, state_d;
    logic                        wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [SDRAM_ADDRS_WIDE-1:0] wr_addrs_q, wr_addrs_d, rd_addrs_q, rd_addrs_d;
    logic [SDRAM_ADDRS_WIDE-1:0] wr_offset_q, wr_offset_d, rd_offset_q, rd_offset_d;
    logic                        wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
    logic                        wr_active_q, wr_active_d, rd_active_q, rd_active_d;
    logic                        wr_start_pend_q, wr_start_pend_d, rd_start_pend_q, rd_start_pend_d;
    logic                        last_grant_q, last_grant_d, grant_q, grant_d;
    logic [2:0]                  busy_cnt_q, busy_cnt_d;
    logic [15:0]                 tmo_cnt_q, tmo_cnt_d;
    logic                        err_q, err_d;

    logic                        wr_req, rd_req, grant_rd, wr_start_now, rd_start_now;
    logic [SDRAM_ADDRS_WIDE-1:0] wr_next, rd_next;
    logic                        data_wide_unused;

    // grant encodings: 1 = read side, 0 = write side
    assign wr_req       = (i_wr_fifo_lvl >= BURST_WORDS) && wr_active_q;
    assign rd_req       = (i_rd_fifo_free >= BURST_WORDS) && rd_active_q;
    assign grant_rd     = rd_req && (!wr_req || !last_grant_q);
    assign wr_start_now = wr_start_pend_q | i_wr_frame_start;
    assign rd_start_now = rd_start_pend_q | i_rd_frame_start;
    assign wr_next      = wr_offset_q + BURST_STEP;
    assign rd_next      = rd_offset_q + BURST_STEP;

    always_comb begin
        state_d         = state_q;
        wr_en_d         = 1'b0;
        rd_en_d         = 1'b0;
        wr_addrs_d      = wr_addrs_q;
        rd_addrs_d      = rd_addrs_q;
        wr_offset_d     = wr_offset_q;
        rd_offset_d     = rd_offset_q;
        wr_buf_d        = wr_buf_q;
        rd_buf_d        = rd_buf_q;
        wr_active_d     = wr_active_q;
        rd_active_d     = rd_active_q;
        wr_start_pend_d = wr_start_now;
        rd_start_pend_d = rd_start_now;
        last_grant_d    = last_grant_q;
        grant_d         = grant_q;
        busy_cnt_d      = busy_cnt_q;
        tmo_cnt_d       = tmo_cnt_q;
        err_d           = err_q;
        case (state_q)
            S_IDLE: begin
                if (wr_start_now) begin
                    wr_offset_d     = '0;
                    wr_active_d     = 1'b1;
                    wr_start_pend_d = 1'b0;
                end
                if (rd_start_now) begin
                    rd_offset_d     = '0;
                    rd_active_d     = 1'b1;
                    rd_buf_d        = ~wr_buf_q;
                    rd_start_pend_d = 1'b0;
                end
                // a frame start moves the offsets this cycle, so the grant waits one cycle
                if (!wr_start_now && !rd_start_now && i_rw_over && (wr_req || rd_req)) begin
                    grant_d = grant_rd;
                    if (grant_rd) begin
                        rd_addrs_d = (rd_buf_q ? BUF1_BASE : BUF0_BASE) + rd_offset_q;
                        rd_en_d    = 1'b1;
                    end else begin
                        wr_addrs_d = (wr_buf_q ? BUF1_BASE : BUF0_BASE) + wr_offset_q;
                        wr_en_d    = 1'b1;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy_cnt_d = '0;
                tmo_cnt_d  = '0;
                state_d    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                if (!i_rw_over) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_cnt_q >= TIMEOUT_CYC) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (busy_cnt_q == 3'd7) begin
                    state_d = S_IDLE;
                end else begin
                    busy_cnt_d = busy_cnt_q + 3'd1;
                end
            end
            S_WAIT_DONE: begin
                if (i_rd_wr_done) begin
                    state_d = S_IDLE;
                    if (!i_rw_nack) begin
                        last_grant_d = grant_q;
                        if (grant_q) begin
                            rd_offset_d = (rd_next >= FRAME_WORDS) ? '0 : rd_next;
                            rd_active_d = (rd_next < FRAME_WORDS);
                        end else if (wr_next >= FRAME_WORDS) begin
                            wr_offset_d = '0;
                            wr_buf_d    = ~wr_buf_q;
                            wr_active_d = 1'b0;
                        end else begin
                            wr_offset_d = wr_next;
                        end
                    end
                end else if (tmo_cnt_q >= TIMEOUT_CYC) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_sdram_init_done) begin
            state_q         <= S_IDLE;
            wr_en_q         <= 1'b0;
            rd_en_q         <= 1'b0;
            wr_addrs_q      <= BUF0_BASE;
            rd_addrs_q      <= BUF1_BASE;
            wr_offset_q     <= '0;
            rd_offset_q     <= '0;
            wr_buf_q        <= 1'b0;
            rd_buf_q        <= 1'b1;
            wr_active_q     <= 1'b0;
            rd_active_q     <= 1'b0;
            wr_start_pend_q <= 1'b0;
            rd_start_pend_q <= 1'b0;
            last_grant_q    <= 1'b1;
            grant_q         <= 1'b0;
            busy_cnt_q      <= '0;
            tmo_cnt_q       <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_en_q         <= wr_en_d;
            rd_en_q         <= rd_en_d;
            wr_addrs_q      <= wr_addrs_d;
            rd_addrs_q      <= rd_addrs_d;
            wr_offset_q     <= wr_offset_d;
            rd_offset_q     <= rd_offset_d;
            wr_buf_q        <= wr_buf_d;
            rd_buf_q        <= rd_buf_d;
            wr_active_q     <= wr_active_d;
            rd_active_q     <= rd_active_d;
            wr_start_pend_q <= wr_start_pend_d;
            rd_start_pend_q <= rd_start_pend_d;
            last_grant_q    <= last_grant_d;
            grant_q         <= grant_d;
            busy_cnt_q      <= busy_cnt_d;
            tmo_cnt_q       <= tmo_cnt_d;
            err_q           <= err_d;
        end
    end

    assign data_wide_unused = (SDRAM_DATA_WIDE != 0);

    assign o_wr_fifo_rd_en = i_wr_data_req;
    assign o_wr_en         = wr_en_q;
    assign o_rd_en         = rd_en_q;
    assign o_wr_lengths    = BURST_LEN;
    assign o_rd_lengths    = BURST_LEN;
    assign o_wr_addrs      = wr_addrs_q;
    assign o_rd_addrs      = rd_addrs_q;
    assign o_wr_dqm        = 4'b0000;
    assign o_rd_dqm        = 4'b0000;
    assign o_err_timeout   = err_q;
    assign o_wr_buf        = wr_buf_q;

endmodule

// File: tb/tb_sdram_frame_port_arb.sv
// tb/tb_sdram_frame_port_arb.sv - randomized and directed bench for sdram_frame_port_arb
module tb_sdram_frame_port_arb;
    localparam logic [20:0] FRAME = 21'd76830;
    localparam int          STEP  = 65;
    localparam int          B1    = 131072;

    logic        clk = 1'b0;
    logic        rst_n, init_done, wr_fs, rd_fs;
    logic [9:0]  wr_lvl, rd_free;
    logic        wr_fifo_rd_en, wr_en, rd_en;
    logic [7:0]  wr_len, rd_len;
    logic [20:0] wr_addrs, rd_addrs;
    logic [3:0]  wr_dqm, rd_dqm;
    logic        data_req, rw_over, done, nack;
    logic        err_tmo, wr_buf;

    int checks = 0;
    int errors = 0;

    // reference view of the frame bookkeeping
    int m_wr_off, m_rd_off;
    bit m_wr_buf, m_rd_buf, m_wr_act, m_rd_act, m_last_rd;

    always #5 clk = ~clk;

    sdram_frame_port_arb #(.FRAME_WORDS(FRAME)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sdram_init_done(init_done),
        .i_wr_frame_start(wr_fs), .i_rd_frame_start(rd_fs),
        .i_wr_fifo_lvl(wr_lvl), .i_rd_fifo_free(rd_free),
        .o_wr_fifo_rd_en(wr_fifo_rd_en),
        .o_wr_en(wr_en), .o_wr_lengths(wr_len), .o_wr_addrs(wr_addrs), .o_wr_dqm(wr_dqm),
        .o_rd_en(rd_en), .o_rd_lengths(rd_len), .o_rd_addrs(rd_addrs), .o_rd_dqm(rd_dqm),
        .i_wr_data_req(data_req), .i_rw_over(rw_over), .i_rd_wr_done(done), .i_rw_nack(nack),
        .o_err_timeout(err_tmo), .o_wr_buf(wr_buf)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; init_done = 1'b1; wr_fs = 1'b0; rd_fs = 1'b0;
        wr_lvl = '0; rd_free = '0; data_req = 1'b0;
        rw_over = 1'b1; done = 1'b0; nack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_wr_off = 0; m_rd_off = 0; m_wr_buf = 0; m_rd_buf = 1;
        m_wr_act = 0; m_rd_act = 0; m_last_rd = 1;
        @(negedge clk);
    endtask

    task automatic model_expect(output bit any, output bit is_rd, output int addr);
        bit wr_ok, rd_ok;
        wr_ok = m_wr_act && (wr_lvl >= STEP);
        rd_ok = m_rd_act && (rd_free >= STEP);
        any   = wr_ok || rd_ok;
        is_rd = rd_ok && (!wr_ok || !m_last_rd);
        addr  = is_rd ? ((m_rd_buf ? B1 : 0) + m_rd_off) : ((m_wr_buf ? B1 : 0) + m_wr_off);
    endtask

    task automatic model_commit(input bit is_rd);
        if (is_rd) begin
            m_rd_off += STEP;
            if (m_rd_off >= int'(FRAME)) begin m_rd_off = 0; m_rd_act = 0; end
        end else begin
            m_wr_off += STEP;
            if (m_wr_off >= int'(FRAME)) begin m_wr_off = 0; m_wr_buf = !m_wr_buf; m_wr_act = 0; end
        end
        m_last_rd = is_rd;
    endtask

    task automatic frame_start(input bit wr, input bit rd);
        wr_lvl = '0; rd_free = '0;
        wr_fs = wr; rd_fs = rd;
        @(negedge clk);
        wr_fs = 1'b0; rd_fs = 1'b0;
        if (wr) begin m_wr_off = 0; m_wr_act = 1; end
        if (rd) begin m_rd_off = 0; m_rd_act = 1; m_rd_buf = !m_wr_buf; end
        @(negedge clk);
    endtask

    task automatic wait_issue(output bit seen, output bit saw_rd, output int addr, output int cyc);
        seen = 0; saw_rd = 0; addr = 0; cyc = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (wr_en || rd_en) begin
                seen = 1; saw_rd = rd_en; cyc = i;
                addr = rd_en ? int'(rd_addrs) : int'(wr_addrs);
                checks++;
                if (wr_en && rd_en) begin
                    errors++; $display("FAIL both_en got wr %0b rd %0b exp one", wr_en, rd_en);
                end
            end
        end
    endtask

    task automatic finish_burst(input bit nk, input int dly, input bit is_rd, input int addr);
        rw_over = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || rd_en !== 1'b0) begin
            errors++; $display("FAIL pulse_width got wr %0b rd %0b exp 0 0", wr_en, rd_en);
        end
        @(negedge clk);
        repeat (dly) @(negedge clk);
        checks++;
        if (int'(is_rd ? rd_addrs : wr_addrs) != addr) begin
            errors++; $display("FAIL addr_stable got %0d exp %0d", is_rd ? rd_addrs : wr_addrs, addr);
        end
        done = 1'b1; nack = nk;
        @(negedge clk);
        done = 1'b0; nack = 1'b0; rw_over = 1'b1;
    endtask

    task automatic do_burst(input bit nk, input int dly, output bit seen, output bit saw_rd, output int addr);
        bit e_any, e_rd;
        int e_addr, cyc;
        model_expect(e_any, e_rd, e_addr);
        wait_issue(seen, saw_rd, addr, cyc);
        checks++;
        if (seen !== e_any) begin
            errors++; $display("FAIL issue_seen got %0b exp %0b", seen, e_any);
        end
        if (seen && e_any) begin
            checks++;
            if (saw_rd !== e_rd) begin
                errors++; $display("FAIL grant_side got rd=%0b exp rd=%0b", saw_rd, e_rd);
            end
            checks++;
            if (addr != e_addr) begin
                errors++; $display("FAIL burst_addr got %0d exp %0d", addr, e_addr);
            end
            checks++;
            if ((saw_rd ? rd_len : wr_len) !== 8'd64 || (saw_rd ? rd_dqm : wr_dqm) !== 4'd0) begin
                errors++; $display("FAIL len_dqm got %0d/%0h exp 64/0",
                                   saw_rd ? rd_len : wr_len, saw_rd ? rd_dqm : wr_dqm);
            end
        end
        if (seen) begin
            finish_burst(nk, dly, saw_rd, addr);
            if (e_any && !nk) model_commit(e_rd);
        end
    endtask

    task automatic test_reset();
        bit seen, srd; int a, c;
        apply_reset();
        checks++;
        if (wr_en !== 1'b0 || rd_en !== 1'b0) begin
            errors++; $display("FAIL reset_en got %0b %0b exp 0 0", wr_en, rd_en);
        end
        checks++;
        if (wr_addrs !== 21'd0 || rd_addrs !== 21'd131072) begin
            errors++; $display("FAIL reset_addrs got %0d %0d exp 0 131072", wr_addrs, rd_addrs);
        end
        checks++;
        if (err_tmo !== 1'b0 || wr_buf !== 1'b0) begin
            errors++; $display("FAIL reset_flags got %0b %0b exp 0 0", err_tmo, wr_buf);
        end
        init_done = 1'b0; wr_fs = 1'b1; rd_fs = 1'b1; wr_lvl = 10'd65; rd_free = 10'd65;
        @(negedge clk);
        wr_fs = 1'b0; rd_fs = 1'b0;
        wait_issue(seen, srd, a, c);
        checks++;
        if (seen) begin
            errors++; $display("FAIL init_hold got issue 1 exp 0");
        end
        init_done = 1'b1; wr_lvl = '0; rd_free = '0;
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 6; i++) begin
            data_req = 1'($urandom);
            #1;
            checks++;
            if (wr_fifo_rd_en !== data_req) begin
                errors++; $display("FAIL data_req_pass got %0b exp %0b", wr_fifo_rd_en, data_req);
            end
            @(negedge clk);
        end
        data_req = 1'b0;
    endtask

    task automatic test_first_write();
        bit seen, srd; int a;
        apply_reset();
        frame_start(1, 0);
        wr_lvl = 10'd64;
        do_burst(0, 0, seen, srd, a);
        wr_lvl = 10'd65;
        do_burst(0, 1, seen, srd, a);
        checks++;
        if (!seen || srd || a != 0) begin
            errors++; $display("FAIL first_write got seen %0b rd %0b addr %0d exp 1 0 0", seen, srd, a);
        end
        do_burst(0, 0, seen, srd, a);
        checks++;
        if (a != STEP) begin
            errors++; $display("FAIL second_write got %0d exp %0d", a, STEP);
        end
    endtask

    task automatic test_alternate();
        bit seen, srd; int a;
        int exp_addr [4] = '{0, B1, STEP, B1 + STEP};
        apply_reset();
        frame_start(1, 1);
        wr_lvl = 10'd65; rd_free = 10'd65;
        for (int i = 0; i < 4; i++) begin
            do_burst(0, $urandom_range(0, 3), seen, srd, a);
            checks++;
            if (srd != ((i % 2) == 1) || a != exp_addr[i]) begin
                errors++; $display("FAIL alternate_%0d got rd %0b addr %0d exp rd %0b addr %0d",
                                   i, srd, a, (i % 2) == 1, exp_addr[i]);
            end
        end
    endtask

    task automatic test_nack();
        bit seen, srd; int a;
        apply_reset();
        frame_start(1, 0);
        wr_lvl = 10'd65;
        do_burst(1, 0, seen, srd, a);
        do_burst(0, 2, seen, srd, a);
        checks++;
        if (a != 0) begin
            errors++; $display("FAIL nack_retry got %0d exp 0", a);
        end
        do_burst(0, 0, seen, srd, a);
        checks++;
        if (a != STEP) begin
            errors++; $display("FAIL after_nack got %0d exp %0d", a, STEP);
        end
    endtask

    task automatic test_busy_retry();
        bit seen, srd; int a0, a1, cyc;
        apply_reset();
        frame_start(1, 0);
        wr_lvl = 10'd65;
        wait_issue(seen, srd, a0, cyc);
        wait_issue(seen, srd, a1, cyc);
        checks++;
        if (!seen || cyc != 10 || a1 != 0) begin
            errors++; $display("FAIL busy_retry got seen %0b gap %0d addr %0d exp 1 10 0", seen, cyc, a1);
        end
        if (seen) begin
            finish_burst(0, 0, 0, a1);
            model_commit(0);
        end
        do_burst(0, 0, seen, srd, a1);
    endtask

    task automatic test_timeout();
        bit seen, srd; int a, c, n;
        apply_reset();
        frame_start(1, 0);
        wr_lvl = 10'd65;
        wait_issue(seen, srd, a, c);
        rw_over = 1'b0;
        n = 0;
        while (err_tmo !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < 4090 || n > 4105) begin
            errors++; $display("FAIL timeout_cycles got %0d exp 4090..4105", n);
        end
        wr_lvl = '0; rw_over = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (err_tmo !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky got %0b exp 1", err_tmo);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen, srd; int a, c;
        wr_lvl = 10'd65;
        do_burst(0, 0, seen, srd, a);
        wait_issue(seen, srd, a, c);
        checks++;
        if (!seen || a != STEP) begin
            errors++; $display("FAIL pre_reset_addr got %0d exp %0d", a, STEP);
        end
        rw_over = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || err_tmo !== 1'b0 || wr_buf !== 1'b0 || wr_addrs !== 21'd0) begin
            errors++; $display("FAIL mid_reset got en %0b err %0b buf %0b addr %0d exp 0 0 0 0",
                               wr_en, err_tmo, wr_buf, wr_addrs);
        end
        apply_reset();
        frame_start(1, 0);
        wr_lvl = 10'd65;
        do_burst(0, 0, seen, srd, a);
        checks++;
        if (a != 0) begin
            errors++; $display("FAIL offset_after_reset got %0d exp 0", a);
        end
    endtask

    task automatic test_frame_wrap();
        bit seen, srd; int a;
        apply_reset();
        frame_start(1, 0);
        wr_lvl = 10'd65;
        for (int i = 0; i < 1182; i++) do_burst(0, 0, seen, srd, a);
        checks++;
        if (wr_buf !== 1'b1) begin
            errors++; $display("FAIL wrap_buf got %0b exp 1", wr_buf);
        end
        do_burst(0, 0, seen, srd, a);
        checks++;
        if (seen) begin
            errors++; $display("FAIL wrap_stop got issue 1 exp 0");
        end
        frame_start(1, 1);
        wr_lvl = 10'd65; rd_free = 10'd65;
        do_burst(0, 0, seen, srd, a);
        checks++;
        if (!srd || a != 0) begin
            errors++; $display("FAIL wrap_read got rd %0b addr %0d exp 1 0", srd, a);
        end
        do_burst(0, 0, seen, srd, a);
        checks++;
        if (srd || a != B1) begin
            errors++; $display("FAIL wrap_write got rd %0b addr %0d exp 0 %0d", srd, a, B1);
        end
    endtask

    task automatic test_random();
        bit seen, srd; int a;
        apply_reset();
        frame_start(1, 1);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) frame_start(1'($urandom), 1'($urandom));
            wr_lvl  = ($urandom_range(0, 2) == 0) ? 10'($urandom_range(0, 64)) : 10'($urandom_range(65, 1023));
            rd_free = ($urandom_range(0, 2) == 0) ? 10'($urandom_range(0, 64)) : 10'($urandom_range(65, 1023));
            do_burst($urandom_range(0, 3) == 0, $urandom_range(0, 3), seen, srd, a);
        end
    endtask

    initial begin
        rst_n = 1'b0; init_done = 1'b0; wr_fs = 1'b0; rd_fs = 1'b0;
        wr_lvl = '0; rd_free = '0; data_req = 1'b0;
        rw_over = 1'b1; done = 1'b0; nack = 1'b0;
        test_reset();
        test_passthrough();
        test_first_write();
        test_alternate();
        test_nack();
        test_busy_retry();
        test_timeout();
        test_reset_mid_wait();
        test_frame_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
